// File: rtl/mem_arbiter.sv
// Round-robin IFU/LSU arbiter driving one memory port for LAT cycles, then a one-cycle response.
// Handshake to next grant is LAT+2 cycles; both readies stay low while a transaction is in flight.
module mem_arbiter #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [63:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [63:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [63:0] lsu_addr,
  input  logic        lsu_we,
  input  logic [63:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [63:0] lsu_rdata,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } req_t;

  localparam logic       OWN_IFU  = 1'b0;
  localparam logic       OWN_LSU  = 1'b1;
  localparam logic [3:0] LAST_CNT = 4'(LAT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        owner;
  logic        last_grant;
  req_t        req_q;
  logic [63:0] ifu_rdata_q;
  logic [63:0] lsu_rdata_q;
  logic        ifu_hs;
  logic        lsu_hs;
  logic        access_done;
  logic [63:0] resp_dat;

  assign ifu_hs      = ifu_req_valid && ifu_req_ready;
  assign lsu_hs      = lsu_req_valid && lsu_req_ready;
  assign access_done = (state == ACCESS) && (cnt == LAST_CNT);
  assign resp_dat    = req_q.we ? 64'h0 : mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    mem_ce         = 1'b0;
    mem_we         = 1'b0;
    case (state)
      IDLE: begin
        // On a conflict the requester that did not win last time goes first.
        if (!reset) begin
          ifu_req_ready = ifu_req_valid && (!lsu_req_valid || last_grant == OWN_LSU);
          lsu_req_ready = lsu_req_valid && (!ifu_req_valid || last_grant == OWN_IFU);
        end
        if (ifu_req_ready || lsu_req_ready) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_ce = 1'b1;
        mem_we = req_q.we;
        if (access_done) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        ifu_resp_valid = !reset && (owner == OWN_IFU);
        lsu_resp_valid = !reset && (owner == OWN_LSU);
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= 4'h0;
      owner       <= OWN_IFU;
      last_grant  <= OWN_IFU;
      req_q       <= '0;
      ifu_rdata_q <= 64'h0;
      lsu_rdata_q <= 64'h0;
    end else begin
      if (ifu_hs) begin
        req_q      <= '{addr: ifu_addr, we: 1'b0, wdata: 64'h0, wmask: 8'h0};
        owner      <= OWN_IFU;
        last_grant <= OWN_IFU;
        cnt        <= 4'h0;
      end else if (lsu_hs) begin
        req_q      <= '{addr: lsu_addr, we: lsu_we, wdata: lsu_wdata, wmask: lsu_wmask};
        owner      <= OWN_LSU;
        last_grant <= OWN_LSU;
        cnt        <= 4'h0;
      end else if (state == ACCESS) begin
        cnt <= cnt + 4'h1;
      end
      // The owner's rdata register doubles as the response register and holds afterwards.
      if (access_done) begin
        if (owner == OWN_LSU) begin
          lsu_rdata_q <= resp_dat;
        end else begin
          ifu_rdata_q <= resp_dat;
        end
      end
    end
  end

  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_wmask = req_q.wmask;
  assign ifu_rdata = ifu_rdata_q;
  assign lsu_rdata = lsu_rdata_q;

endmodule
